// File: rtl/pdm_sched_pkg.sv
// pdm_sched_pkg: shared types and constants for the PDM capture scheduler.
package pdm_sched_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_e;
   typedef struct packed {
      logic [1:0]  ch;
      logic [15:0] data;
   } fifo_entry_t;
   localparam logic [7:0] MIN_DIV = 8'd1;
endpackage

// File: rtl/pdm_sched_fifo.sv
// pdm_sched_fifo: output sample FIFO; read side shows zero when empty.
module pdm_sched_fifo import pdm_sched_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        wr_i,
   input  fifo_entry_t wdata_i,
   input  logic        rd_i,
   output fifo_entry_t rdata_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;
   logic [AW:0] wptr_q, rptr_q;
   fifo_entry_t mem_q [DEPTH];
   assign empty_o = wptr_q == rptr_q;
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_i) wptr_q <= wptr_q + ONE;
         if (rd_i) rptr_q <= rptr_q + ONE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/pdm_cic_sched.sv
// pdm_cic_sched: PDM clock divider, per-channel bit capture and CIC issue
// sequencer, plus a tagged output FIFO for decimated samples.
module pdm_cic_sched import pdm_sched_pkg::*; #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_en_i,
   input  logic [7:0]  cfg_clkdiv_i,
   input  logic [1:0]  cfg_ch_num_i,
   output logic        pdm_clk_o,
   input  logic [1:0]  pdm_data_i,
   output logic        cic_en_o,
   output logic        cic_data_o,
   output logic        cic_valid_o,
   output logic [1:0]  cic_ch_o,
   input  logic        sample_valid_i,
   input  logic [15:0] sample_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] out_data_o,
   output logic [1:0]  out_ch_o,
   output logic        overflow_o
);
   logic en_q, pclk_q, hi_seen_q, ovf_q;
   logic [7:0] div_q, div_max;
   logic [1:0] och_q, seq_q, seq_d;
   logic [3:0] cap_q, snap_q;
   state_e state_q, state_d;
   logic rise, tc, hi_cap, lo_cap, start, full, empty, rd, wr;
   fifo_entry_t wr_ent, rd_ent;
   assign rise    = cfg_en_i & ~en_q;
   assign div_max = (cfg_clkdiv_i < MIN_DIV) ? MIN_DIV : cfg_clkdiv_i;
   assign tc      = cfg_en_i & ~rise & (div_q == div_max);
   assign hi_cap  = tc & pclk_q;
   assign lo_cap  = tc & ~pclk_q;
   // a frame only starts once a high phase has been captured since enable
   assign start   = lo_cap & hi_seen_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q      <= 1'b0;
         pclk_q    <= 1'b0;
         hi_seen_q <= 1'b0;
         ovf_q     <= 1'b0;
         div_q     <= '0;
         och_q     <= '0;
         cap_q     <= '0;
         snap_q    <= '0;
         seq_q     <= '0;
         state_q   <= IDLE;
      end else begin
         en_q    <= cfg_en_i;
         state_q <= state_d;
         seq_q   <= seq_d;
         if (!cfg_en_i || rise) begin
            div_q     <= '0;
            pclk_q    <= 1'b0;
            hi_seen_q <= 1'b0;
         end else if (tc) begin
            div_q  <= '0;
            pclk_q <= ~pclk_q;
         end else begin
            div_q <= div_q + 8'd1;
         end
         if (hi_cap) begin
            cap_q[0]  <= pdm_data_i[0];
            cap_q[2]  <= pdm_data_i[1];
            hi_seen_q <= 1'b1;
         end
         if (lo_cap) begin
            cap_q[1] <= pdm_data_i[0];
            cap_q[3] <= pdm_data_i[1];
         end
         if (start) snap_q <= {pdm_data_i[1], cap_q[2], pdm_data_i[0], cap_q[0]};
         if (rise) begin
            och_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (sample_valid_i) och_q <= (och_q == cfg_ch_num_i) ? 2'd0 : och_q + 2'd1;
            if (sample_valid_i && full && !rd) ovf_q <= 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      if (!cfg_en_i) begin
         state_d = IDLE;
         seq_d   = '0;
      end else if (rise) begin
         state_d = WAIT;
         seq_d   = '0;
      end else if (state_q != IDLE && start) begin
         state_d = ISSUE;
         seq_d   = '0;
      end else if (state_q == ISSUE) begin
         state_d = (seq_q == cfg_ch_num_i) ? WAIT : ISSUE;
         seq_d   = (seq_q == cfg_ch_num_i) ? 2'd0 : seq_q + 2'd1;
      end
   end
   assign pdm_clk_o   = pclk_q;
   assign cic_en_o    = en_q;
   assign cic_valid_o = state_q == ISSUE;
   assign cic_ch_o    = seq_q;
   assign cic_data_o  = cic_valid_o & snap_q[seq_q];
   assign overflow_o  = ovf_q;
   assign rd          = out_valid_o & out_ready_i;
   assign wr          = sample_valid_i & (~full | rd);
   assign wr_ent      = '{ch: och_q, data: sample_data_i};
   assign out_valid_o = ~empty;
   assign out_data_o  = rd_ent.data;
   assign out_ch_o    = rd_ent.ch;
   pdm_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (rise),
      .wr_i    (wr),
      .wdata_i (wr_ent),
      .rd_i    (rd),
      .rdata_o (rd_ent),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_pdm_cic_sched.sv
// tb_pdm_cic_sched: directed and random checks of pdm_cic_sched against a
// timing-formula PDM model and a queue-based FIFO model.
module tb_pdm_cic_sched;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst, cfg_en, pdm_clk, cic_en, cic_data, cic_valid;
   logic sample_valid, out_valid, out_ready, ovf;
   logic [7:0] cfg_div;
   logic [1:0] cfg_ch, pdm_data, cic_ch, out_ch;
   logic [15:0] sample_data, out_data;
   int ncmp = 0, nfail = 0;
   logic en_prev = 1'b0;
   bit active = 0, pat_mode = 0;
   int n = 0;
   logic [1:0] pd_hist [8192];
   logic [17:0] mq [$];
   logic [17:0] obs [$];
   logic [1:0] m_och = 2'd0;
   logic m_ovf = 1'b0;
   logic [3:0] pat = 4'b1001;

   pdm_cic_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_clkdiv_i(cfg_div),
      .cfg_ch_num_i(cfg_ch), .pdm_clk_o(pdm_clk), .pdm_data_i(pdm_data),
      .cic_en_o(cic_en), .cic_data_o(cic_data), .cic_valid_o(cic_valid),
      .cic_ch_o(cic_ch), .sample_valid_i(sample_valid), .sample_data_i(sample_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_ch_o(out_ch), .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      bit rise, m_rd, exp_v;
      int h, c, i;
      logic [1:0] e0, e1;
      logic [3:0] snap;
      logic exp_d;
      if (out_valid && out_ready) obs.push_back({out_ch, out_data});
      m_rd = (mq.size() > 0) && out_ready;
      rise = cfg_en && !en_prev;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_och = 2'd0;
         m_ovf = 1'b0;
         active = 0;
         en_prev = 1'b0;
      end else begin
         if (rise) begin
            mq.delete();
            m_och = 2'd0;
            m_ovf = 1'b0;
         end else begin
            if (m_rd) void'(mq.pop_front());
            if (sample_valid) begin
               if (mq.size() < DEPTH) mq.push_back({m_och, sample_data});
               else m_ovf = 1'b1;
               m_och = (m_och == cfg_ch) ? 2'd0 : m_och + 2'd1;
            end
         end
         if (rise) begin
            active = 1;
            n = 0;
         end else if (!cfg_en) active = 0;
         else n++;
         if (active && n < 8192) pd_hist[n] = pdm_data;
         en_prev = cfg_en;
      end
      // half period h cycles; low-phase ends at n = odd*h, first one only primes
      h = ((cfg_div < 8'd1) ? 1 : int'(cfg_div)) + 1;
      c = int'(cfg_ch) + 1;
      exp_v = 0;
      exp_d = 1'b0;
      i = 0;
      if (active) begin
         for (int q = 3; q * h <= n; q += 2) begin
            if (n - q * h < c) begin
               exp_v = 1;
               i = n - q * h;
               e0 = pd_hist[(q - 1) * h];
               e1 = pd_hist[q * h];
               snap = {e1[1], e0[1], e1[0], e0[0]};
               exp_d = snap[i];
            end
         end
      end
      chk("cic_en", cic_en, en_prev);
      chk("pdm_clk", pdm_clk, active ? ((n / h) % 2) : 0);
      chk("cic_valid", cic_valid, exp_v);
      if (exp_v) begin
         chk("cic_ch", cic_ch, i);
         chk("cic_data", cic_data, exp_d);
         if (pat_mode) chk("pattern", cic_data, pat[i]);
      end
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("out_data", out_data, mq[0][15:0]);
         chk("out_ch", out_ch, mq[0][17:16]);
      end
      chk("overflow", ovf, m_ovf);
      if (rst) begin
         chk("rst_out_data", out_data, 0);
         chk("rst_out_ch", out_ch, 0);
         chk("rst_cic_ch", cic_ch, 0);
         chk("rst_cic_data", cic_data, 0);
      end
   endtask

   task automatic run(input int k, input bit rnd);
      repeat (k) begin
         pdm_data = pat_mode ? (pdm_clk ? 2'b01 : 2'b10) : 2'($urandom);
         if (rnd) begin
            sample_valid = ($urandom % 3) == 0;
            sample_data = 16'($urandom);
            out_ready = 1'($urandom);
         end
         step();
      end
   endtask

   initial begin
      bit found;
      rst = 1'b1; cfg_en = 1'b0; cfg_div = 8'd3; cfg_ch = 2'd3;
      pdm_data = 2'b00; sample_valid = 1'b0; sample_data = '0; out_ready = 1'b0;
      step();
      step();
      cfg_en = 1'b1;
      step();
      rst = 1'b0;
      pat_mode = 1;
      run(70, 0);
      pat_mode = 0;
      cfg_en = 1'b0; run(2, 0);
      cfg_div = 8'd0; cfg_ch = 2'd0; cfg_en = 1'b1;
      run(40, 0);
      cfg_en = 1'b0; run(2, 0);
      cfg_ch = 2'd1; cfg_en = 1'b1; out_ready = 1'b1;
      run(1, 0);
      obs.delete();
      for (int k = 1; k <= 5; k++) begin
         sample_valid = 1'b1; sample_data = 16'(k);
         run(1, 0);
         sample_valid = 1'b0;
         run(1, 0);
      end
      run(3, 0);
      chk("tag_count", obs.size(), 5);
      for (int k = 0; k < obs.size() && k < 5; k++) begin
         chk("tag_ch", obs[k][17:16], k % 2);
         chk("tag_data", obs[k][15:0], k + 1);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample_valid = 1'b1; sample_data = 16'(8'h11 + k);
         run(1, 0);
      end
      sample_valid = 1'b0;
      run(1, 0);
      chk("ovf_set", ovf, 1);
      obs.delete();
      out_ready = 1'b1;
      run(6, 0);
      chk("drain_count", obs.size(), 4);
      for (int k = 0; k < obs.size() && k < 4; k++) chk("drain_data", obs[k][15:0], 8'h11 + k);
      cfg_en = 1'b0; run(1, 0);
      cfg_en = 1'b1; run(1, 0);
      chk("ovf_clear", ovf, 0);
      cfg_en = 1'b0; run(2, 0);
      cfg_div = 8'd1; cfg_ch = 2'd3; cfg_en = 1'b1;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (cic_valid && cic_ch == 2'd1) found = 1;
         else run(1, 0);
      end
      chk("abort_wait", found, 1);
      cfg_en = 1'b0;
      run(1, 0);
      chk("abort_valid", cic_valid, 0);
      chk("abort_pclk", pdm_clk, 0);
      run(4, 0);
      cfg_en = 1'b1;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         run(1, 0);
         if (cic_valid) found = 1;
      end
      chk("restart_wait", found, 1);
      chk("restart_ch", cic_ch, 0);
      for (int r = 0; r < 6; r++) begin
         cfg_en = 1'b0;
         run(3, 1);
         cfg_div = 8'($urandom_range(0, 4));
         cfg_ch = 2'($urandom);
         cfg_en = 1'b1;
         run(150, 1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
